// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

   localparam int          BMASK_W    = 4;
   localparam int          DATA_W     = 32;
   localparam logic [3:0]  BMASK_FULL = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_RESP
   } state_t;

   typedef enum logic {
      OWN_IF,
      OWN_LS
   } owner_t;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way picker: lone requester wins; ties go to LS (fixed) or to whoever was not last granted.
module rr_pick2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  owner_t     last_owner,
   input  logic       fixed_prio,
   output owner_t     winner,
   output logic       grant_valid
);

   always_comb begin
      grant_valid = |req;
      winner      = OWN_IF;
      if (req == 2'b11) begin
         if (fixed_prio || (last_owner == OWN_IF))
            winner = OWN_LS;
         else
            winner = OWN_IF;
      end else if (req[1]) begin
         winner = OWN_LS;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and LS requesters onto one single-port memory with a req/ack handshake.
// Optional REQ-state watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter bit LS_FIXED_PRIO  = 1'b0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic [DATA_W-1:0]   o_if_rdata,
   output logic                o_if_ack,
   input  logic                i_ls_req,
   input  logic                i_ls_we,
   input  logic [ADDR_W-1:0]   i_ls_addr,
   input  logic [DATA_W-1:0]   i_ls_wdata,
   input  logic [BMASK_W-1:0]  i_ls_bmask,
   output logic [DATA_W-1:0]   o_ls_rdata,
   output logic                o_ls_ack,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [BMASK_W-1:0]  o_mem_bmask,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   input  logic                i_mem_ack,
   output logic                o_err,
   output logic                o_busy
);

   state_t state_q, state_d;
   owner_t owner_q, last_q, pick_owner;
   logic   pick_valid;
   logic   tmo_hit;

   rr_pick2 u_pick (
      .req         ({i_ls_req, i_if_req}),
      .last_owner  (last_q),
      .fixed_prio  (LS_FIXED_PRIO),
      .winner      (pick_owner),
      .grant_valid (pick_valid)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] tmo_cnt_q;
   logic        err_q;

   assign tmo_hit = (state_q == ST_REQ) && (tmo_cnt_q == TMO_LAST);

   // Counter is zero whenever REQ is entered; an ack on the limit cycle wins over the timeout.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         tmo_cnt_q <= '0;
         err_q     <= 1'b0;
      end else if (state_q != ST_REQ) begin
         tmo_cnt_q <= '0;
         if (state_q == ST_IDLE)
            err_q <= 1'b0;
      end else begin
         if (!i_mem_ack)
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
         err_q <= !i_mem_ack && tmo_hit;
      end
   end

   assign o_err = (state_q == ST_RESP) && err_q;
`else
   logic unused_tmo;
   assign unused_tmo = ^TIMEOUT_CYCLES;
   assign tmo_hit    = 1'b0;
   assign o_err      = 1'b0;
`endif

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_valid) state_d = ST_REQ;
         ST_REQ:  if (i_mem_ack || tmo_hit) state_d = ST_RESP;
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      o_mem_req = (state_q == ST_REQ);
      o_busy    = (state_q != ST_IDLE);
      o_if_ack  = (state_q == ST_RESP) && (owner_q == OWN_IF);
      o_ls_ack  = (state_q == ST_RESP) && (owner_q == OWN_LS);
   end

   // Payload latched once at grant so the memory sees it stable for the whole REQ phase.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         owner_q     <= OWN_IF;
         last_q      <= OWN_IF;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_mem_bmask <= '0;
         o_if_rdata  <= '0;
         o_ls_rdata  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  owner_q <= pick_owner;
                  if (pick_owner == OWN_LS) begin
                     o_mem_we    <= i_ls_we;
                     o_mem_addr  <= i_ls_addr;
                     o_mem_wdata <= i_ls_wdata;
                     o_mem_bmask <= i_ls_bmask;
                  end else begin
                     o_mem_we    <= 1'b0;
                     o_mem_addr  <= i_if_addr;
                     o_mem_wdata <= '0;
                     o_mem_bmask <= BMASK_FULL;
                  end
               end
            end
            ST_REQ: begin
               if (i_mem_ack) begin
                  if (owner_q == OWN_LS)
                     o_ls_rdata <= o_mem_we ? '0 : i_mem_rdata;
                  else
                     o_if_rdata <= o_mem_we ? '0 : i_mem_rdata;
               end else if (tmo_hit) begin
                  if (owner_q == OWN_LS)
                     o_ls_rdata <= '0;
                  else
                     o_if_rdata <= '0;
               end
            end
            ST_RESP: last_q <= owner_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance (dut) and fixed-priority instance (dut_fp) share all inputs.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        ls_req = 1'b0;
   logic        ls_we = 1'b0;
   logic [31:0] ls_addr = '0;
   logic [31:0] ls_wdata = '0;
   logic [3:0]  ls_bmask = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;

   logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
   logic        if_ack, ls_ack, mem_req, mem_we, err, busy;
   logic [3:0]  mem_bmask;

   logic [31:0] fp_if_rdata, fp_ls_rdata, fp_mem_addr, fp_mem_wdata;
   logic        fp_if_ack, fp_ls_ack, fp_mem_req, fp_mem_we, fp_err, fp_busy;
   logic [3:0]  fp_mem_bmask;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .LS_FIXED_PRIO(1'b0), .TIMEOUT_CYCLES(4)) dut (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .i_ls_bmask(ls_bmask), .o_ls_rdata(ls_rdata), .o_ls_ack(ls_ack),
      .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_mem_bmask(mem_bmask), .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack),
      .o_err(err), .o_busy(busy)
   );

   mem_port_arbiter #(.ADDR_W(32), .LS_FIXED_PRIO(1'b1), .TIMEOUT_CYCLES(4)) dut_fp (
      .i_clk(clk), .i_reset(rst),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(fp_if_rdata), .o_if_ack(fp_if_ack),
      .i_ls_req(ls_req), .i_ls_we(ls_we), .i_ls_addr(ls_addr), .i_ls_wdata(ls_wdata),
      .i_ls_bmask(ls_bmask), .o_ls_rdata(fp_ls_rdata), .o_ls_ack(fp_ls_ack),
      .o_mem_req(fp_mem_req), .o_mem_we(fp_mem_we), .o_mem_addr(fp_mem_addr),
      .o_mem_wdata(fp_mem_wdata), .o_mem_bmask(fp_mem_bmask), .i_mem_rdata(mem_rdata),
      .i_mem_ack(mem_ack), .o_err(fp_err), .o_busy(fp_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_memreq"}, {31'd0, mem_req}, 32'd0);
      chk({tag, "_ifack"}, {31'd0, if_ack}, 32'd0);
      chk({tag, "_lsack"}, {31'd0, ls_ack}, 32'd0);
      chk({tag, "_err"}, {31'd0, err}, 32'd0);
   endtask

   initial begin
      logic [31:0] a;

      // Reset state
      tick(); tick();
      chk_idle("rst");
      chk("rst_ifrd", if_rdata, 32'h0);
      chk("rst_lsrd", ls_rdata, 32'h0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_bmask", {28'd0, mem_bmask}, 32'h0);
      rst = 1'b0;
      tick();
      chk_idle("post_rst");

      // IF-only read, zero-wait memory
      if_req = 1'b1; if_addr = 32'h0000_0010;
      tick();
      chk("if_memreq", {31'd0, mem_req}, 32'd1);
      chk("if_addr", mem_addr, 32'h0000_0010);
      chk("if_bmask", {28'd0, mem_bmask}, 32'hF);
      chk("if_we", {31'd0, mem_we}, 32'd0);
      chk("if_noack_req", {31'd0, if_ack}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      tick();
      mem_ack = 1'b0; if_req = 1'b0;
      chk("if_ack", {31'd0, if_ack}, 32'd1);
      chk("if_rdata", if_rdata, 32'hDEAD_BEEF);
      chk("if_lsack", {31'd0, ls_ack}, 32'd0);
      chk("if_memreq_drop", {31'd0, mem_req}, 32'd0);
      tick();
      chk_idle("if_done");

      // Simultaneous requests after reset, both held
      rst = 1'b1; #1;
      tick();
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h0000_0100;
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_wdata = 32'h0; ls_bmask = 4'hF;
      for (int r = 0; r < 4; r++) begin
         a = 32'hA000_0000 + 32'(r);
         tick();
         chk("tie_addr", mem_addr, (r % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
         chk("tie_fp_addr", fp_mem_addr, 32'h0000_0200);
         mem_ack = 1'b1; mem_rdata = a;
         tick();
         mem_ack = 1'b0;
         chk("tie_lsack", {31'd0, ls_ack}, (r % 2 == 0) ? 32'd1 : 32'd0);
         chk("tie_ifack", {31'd0, if_ack}, (r % 2 == 0) ? 32'd0 : 32'd1);
         chk("tie_rdata", (r % 2 == 0) ? ls_rdata : if_rdata, a);
         chk("tie_fp_lsack", {31'd0, fp_ls_ack}, 32'd1);
         chk("tie_fp_ifack", {31'd0, fp_if_ack}, 32'd0);
         chk("tie_fp_rdata", fp_ls_rdata, a);
         if (r == 3) begin
            if_req = 1'b0; ls_req = 1'b0;
         end
         tick();
      end
      tick();
      chk_idle("tie_done");

      // LS write with three wait states
      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h7000_0000; ls_wdata = 32'h1234_5678; ls_bmask = 4'h3;
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("wr_memreq", {31'd0, mem_req}, 32'd1);
         chk("wr_we", {31'd0, mem_we}, 32'd1);
         chk("wr_addr", mem_addr, 32'h7000_0000);
         chk("wr_wdata", mem_wdata, 32'h1234_5678);
         chk("wr_bmask", {28'd0, mem_bmask}, 32'h3);
         chk("wr_noack", {31'd0, ls_ack}, 32'd0);
         if (i == 3) begin
            mem_ack = 1'b1; mem_rdata = 32'hFFFF_0000;
         end
         tick();
      end
      mem_ack = 1'b0; ls_req = 1'b0;
      chk("wr_ack", {31'd0, ls_ack}, 32'd1);
      chk("wr_rdata", ls_rdata, 32'h0);
      chk("wr_ifack", {31'd0, if_ack}, 32'd0);
      tick();
      chk_idle("wr_done");

      // Stray ack in IDLE
      mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
      tick();
      chk_idle("stray1");
      tick();
      chk_idle("stray2");
      chk("stray_ifrd", if_rdata, 32'hA000_0003);
      mem_ack = 1'b0;

      // Timeout behaviour (limit 4 REQ cycles when enabled)
      if_req = 1'b1; if_addr = 32'h0000_0020;
      tick();
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         chk("tmo_memreq", {31'd0, mem_req}, 32'd1);
         chk("tmo_err_early", {31'd0, err}, 32'd0);
         tick();
      end
      if_req = 1'b0;
      chk("tmo_memreq_drop", {31'd0, mem_req}, 32'd0);
      chk("tmo_ack", {31'd0, if_ack}, 32'd1);
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_rdata", if_rdata, 32'h0);
      tick();
      chk_idle("tmo_done");
`else
      for (int i = 0; i < 10; i++) begin
         chk("notmo_memreq", {31'd0, mem_req}, 32'd1);
         chk("notmo_err", {31'd0, err}, 32'd0);
         chk("notmo_noack", {31'd0, if_ack}, 32'd0);
         tick();
      end
      mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
      tick();
      mem_ack = 1'b0; if_req = 1'b0;
      chk("notmo_ack", {31'd0, if_ack}, 32'd1);
      chk("notmo_err_ack", {31'd0, err}, 32'd0);
      chk("notmo_rdata", if_rdata, 32'h5555_AAAA);
      tick();
      chk_idle("notmo_done");
`endif

      // Reset in the middle of REQ
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0300; ls_bmask = 4'hF;
      tick();
      chk("mid_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk_idle("mid_rst");
      chk("mid_addr", mem_addr, 32'h0);
      chk("mid_lsrd", ls_rdata, 32'h0);
      ls_req = 1'b0;
      tick();
      rst = 1'b0;
      mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
      tick();
      chk_idle("mid_stray");
      chk("mid_lsrd2", ls_rdata, 32'h0);
      mem_ack = 1'b0;

      // Normal LS read after the reset
      ls_req = 1'b1; ls_addr = 32'h0000_0044;
      tick();
      chk("post_addr", mem_addr, 32'h0000_0044);
      chk("post_memreq", {31'd0, mem_req}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
      tick();
      mem_ack = 1'b0; ls_req = 1'b0;
      chk("post_ack", {31'd0, ls_ack}, 32'd1);
      chk("post_rdata", ls_rdata, 32'h0BAD_F00D);
      tick();
      chk_idle("post_done");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single-port memory/bus slave between two requesters of the RISC-V core: the instruction-fetch path (IF, read-only) and the load/store unit (LS, read/write with byte mask).
- Sits between the datapath and the unified memory / memory-mapped I/O (LEDs, HEX, LCD, switches).
- Grants one transaction at a time and handles a variable-latency memory handshake.
- Returns per-requester one-cycle ack pulses; the core stalls on these.

Parameters:
- ADDR_W, 32, address width of all ports.
- LS_FIXED_PRIO, 0, 0 = round-robin on simultaneous requests; 1 = LS always wins ties.
- TIMEOUT_CYCLES, 255, REQ-state wait limit. Used only when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_if_req  in  1  IF read request; held with stable addr until o_if_ack.
- i_if_addr  in  ADDR_W  IF byte address.
- o_if_rdata  out  32  IF read data; valid with o_if_ack.
- o_if_ack  out  1  one-cycle completion pulse to IF.
- i_ls_req  in  1  LS request; held with stable payload until o_ls_ack.
- i_ls_we  in  1  1 = write, 0 = read.
- i_ls_addr  in  ADDR_W  LS byte address.
- i_ls_wdata  in  32  LS write data.
- i_ls_bmask  in  4  LS byte enables.
- o_ls_rdata  out  32  LS read data; valid with o_ls_ack.
- o_ls_ack  out  1  one-cycle completion pulse to LS.
- o_mem_req  out  1  memory request, held until i_mem_ack.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  ADDR_W  memory address.
- o_mem_wdata  out  32  memory write data.
- o_mem_bmask  out  4  memory byte enables. Forced to 4'hF for IF reads.
- i_mem_rdata  in  32  memory read data; valid when i_mem_ack = 1.
- i_mem_ack  in  1  memory completion; meaningful only while o_mem_req = 1.
- o_err  out  1  timeout error pulse, coincident with ack. Tied 0 without the macro.
- o_busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset (asynchronous, any state, including mid-transaction):
  - State goes to IDLE; any in-flight transaction is discarded with no ack.
  - All outputs are 0, including both rdata outputs; last-grant pointer = IF.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any request is sampled high at a clock edge, pick the winner.
  - Latch the winner's addr, we, wdata and bmask into the o_mem_* registers (IF: we = 0, wdata = 0, bmask = F).
  - Record the owner and go to REQ.
  - With no request, stay in IDLE.
- REQ:
  - o_mem_req = 1; the o_mem_* payload is stable.
  - On i_mem_ack = 1: capture i_mem_rdata (or 0 if we = 1) into the owner's rdata register, then go to RESP.
- RESP:
  - o_mem_req = 0; the owner's ack = 1 for exactly this cycle.
  - Update the last-grant pointer to the owner and go to IDLE.
- rdata registers hold their value until the next ack to that requester.
- Latency:
  - Request first sampled at edge k; o_mem_req is high in cycle k+1.
  - With a zero-wait i_mem_ack, the ack comes in cycle k+2.
  - Throughput: one transaction per 3 cycles minimum.
- Tie-break:
  - LS_FIXED_PRIO = 0: grant the requester that was not last granted; the first tie after reset goes to LS.
  - LS_FIXED_PRIO = 1: LS always wins.
  - A lone requester is always granted.
- i_mem_ack in IDLE or RESP is ignored.
- Requests arriving while busy wait.
- A requester must drop or change its request on the edge ending its ack cycle; the next IDLE then sees the fresh request.
- Never two acks in one cycle; at most one outstanding memory transaction.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES, drop o_mem_req and go to RESP with owner rdata = 0.
  - o_err = 1 together with the ack.
  - An i_mem_ack in the same cycle as the limit takes priority: normal completion, no error.
- Undefined: no counter; REQ waits indefinitely; o_err is constant 0.

Decomposition:
- Package mem_arb_pkg:
  - State enum {ST_IDLE, ST_REQ, ST_RESP}.
  - Owner enum {OWN_IF, OWN_LS}.
  - Localparams BMASK_W = 4, DATA_W = 32, BMASK_FULL = 4'hF.
- Sub-module rr_pick2: combinational two-way round-robin/fixed-priority picker.
  - Inputs: req[1:0], last owner, fixed_prio.
  - Output: winner owner and grant_valid.
  - FSM, registers and counter stay in mem_port_arbiter.

Test Plan:
- IF-only read: i_if_req = 1, addr 0x0000_0010; memory acks in the first REQ cycle with 0xDEAD_BEEF → o_mem_req high for 1 cycle with bmask F, we 0; o_if_ack pulses 2 cycles after the request edge with rdata 0xDEAD_BEEF; o_ls_ack stays 0.
- LS write, 3 wait states: we = 1, addr 0x7000_0000, wdata 0x1234_5678, bmask 0x3 → o_mem_* hold exactly those values for 4 REQ cycles; o_ls_ack 1 cycle after i_mem_ack; o_ls_rdata = 0.
- Simultaneous requests after reset, both held:
  - LS_FIXED_PRIO = 0 → grant order LS, IF, LS, IF.
  - LS_FIXED_PRIO = 1 → LS every time until it drops.
- Reset mid-REQ: assert i_reset during REQ → all outputs 0 immediately; no ack issued; a later i_mem_ack in IDLE is ignored; the next request proceeds normally.
- Timeout (macro on, TIMEOUT_CYCLES = 4): never ack → o_mem_req drops after 4 REQ cycles; owner ack plus o_err pulse together with rdata 0. Same stimulus with the macro off → o_mem_req stays high indefinitely and o_err = 0.
- Stray ack: i_mem_ack = 1 in IDLE with no requests → no state change, no acks, o_busy = 0.
